// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode constants, reset PC and fetch-state encoding
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetchState_t;

endpackage

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - combinational next-PC select: jump, taken branch, or sequential
module ifu_npc (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] npc
);

  logic [31:0] branchOffset;

  assign branchOffset = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (jump) begin
      npc = {pc_plus4[31:28], inst[25:0], 2'b00};
    end else if (branch && zero) begin
      npc = pc_plus4 + branchOffset;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch stage: PC, imem handshake, instruction register
// Optional retire counter output enabled by defining IFU_RETIRE_CNT_EN.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef IFU_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  fetchState_t state, nextState;
  logic        retire;
  logic [31:0] npc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    retire    = 1'b0;
    case (state)
      S_REQ:  nextState = S_WAIT;
      S_WAIT: if (imem_rvalid) nextState = S_HOLD;
      S_HOLD: begin
        if (!stall) begin
          retire    = 1'b1;
          nextState = S_REQ;
        end
      end
      default: nextState = S_REQ;
    endcase
  end

  // Request is gated by rst so nothing is issued while reset is held.
  assign imem_req  = (state == S_REQ) & ~rst;
  assign imem_addr = pc;
  assign op        = inst[31:26];
  assign pc_plus4  = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_RESET & ~32'd3;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
    end else begin
      if ((state == S_WAIT) && imem_rvalid) begin
        inst       <= imem_rdata;
        inst_valid <= 1'b1;
      end
      if (retire) begin
        pc         <= npc & ~32'd3;
        inst_valid <= 1'b0;
      end
    end
  end

  ifu_npc uNpc (
    .pc_plus4 (pc_plus4),
    .inst     (inst[25:0]),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .npc      (npc)
  );

`ifdef IFU_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= 32'd0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed plus randomized fetch sequences against a next-PC model
module tb_ifetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imemReq, instValid;
  logic [31:0] imemAddr, inst, pc, pcPlus4;
  logic [5:0]  op;
  logic        imemRvalid = 1'b0;
  logic [31:0] imemRdata  = 32'd0;
  logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, zero = 1'b0;
`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retireCnt, retireCnt2;
`endif

  logic        req2, valid2, rvalid2;
  logic [31:0] addr2, inst2, pc2, pcPlus42;
  logic [5:0]  op2;
  logic [31:0] addrLog2[$];

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
    .stall(stall), .branch(branch), .jump(jump), .zero(zero),
    .inst_valid(instValid), .inst(inst), .op(op), .pc(pc), .pc_plus4(pcPlus4)
`ifdef IFU_RETIRE_CNT_EN
    , .retire_cnt(retireCnt)
`endif
  );

  ifetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(32'd0),
    .stall(1'b0), .branch(1'b0), .jump(1'b0), .zero(1'b0),
    .inst_valid(valid2), .inst(inst2), .op(op2), .pc(pc2), .pc_plus4(pcPlus42)
`ifdef IFU_RETIRE_CNT_EN
    , .retire_cnt(retireCnt2)
`endif
  );

  always @(posedge clk or posedge rst) begin
    if (rst) rvalid2 <= 1'b0;
    else     rvalid2 <= req2;
  end

  always @(posedge clk) begin
    if (rst) addrLog2.delete();
    else if (req2) addrLog2.push_back(addr2);
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] expPc;
  logic [31:0] expCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refNpc(input logic [31:0] cur, input logic [31:0] w,
                                         input logic br, input logic jp, input logic zr);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(w[15:0]));
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (br && zr) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst = 1'b1; imemRvalid = 1'b0; stall = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rstReq", 32'(imemReq), 32'd0);
    chk("rstValid", 32'(instValid), 32'd0);
    chk("rstPc", pc, 32'h0000_3000);
    chk("rstInst", inst, 32'd0);
    chk("rstOp", 32'(op), 32'd0);
    chk("rstPcPlus4", pcPlus4, 32'h0000_3004);
`ifdef IFU_RETIRE_CNT_EN
    chk("rstCnt", retireCnt, 32'd0);
`endif
    rst = 1'b0;
    expPc  = 32'h0000_3000;
    expCnt = 32'd0;
  endtask

  // Entered at a point in the REQ cycle; leaves at the negedge after retire.
  task automatic doFetch(input logic [31:0] w, input int k, input int stalls,
                         input logic br, input logic jp, input logic zr, input logic junkReq);
    #1;
    chk("reqHigh", 32'(imemReq), 32'd1);
    chk("reqAddr", imemAddr, expPc);
    chk("reqValidLow", 32'(instValid), 32'd0);
    if (junkReq) begin
      imemRvalid = 1'b1;
      imemRdata  = $urandom;
    end
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      chk("waitNoReq", 32'(imemReq), 32'd0);
      chk("waitValidLow", 32'(instValid), 32'd0);
      imemRvalid = (j == k);
      imemRdata  = (j == k) ? w : $urandom;
    end
    @(negedge clk);
    imemRvalid = 1'b0;
    chk("holdValid", 32'(instValid), 32'd1);
    chk("holdInst", inst, w);
    chk("holdOp", 32'(op), 32'(w[31:26]));
    chk("holdPc", pc, expPc);
    chk("holdPcPlus4", pcPlus4, expPc + 32'd4);
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
      imemRvalid = 1'($urandom);
      imemRdata  = $urandom;
      @(negedge clk);
      chk("stallValid", 32'(instValid), 32'd1);
      chk("stallInst", inst, w);
      chk("stallPc", pc, expPc);
      chk("stallNoReq", 32'(imemReq), 32'd0);
    end
    stall = 1'b0; imemRvalid = 1'b0;
    branch = br; jump = jp; zero = zr;
`ifdef IFU_RETIRE_CNT_EN
    chk("cntBefore", retireCnt, expCnt);
`endif
    @(negedge clk);
    expPc  = refNpc(expPc, w, br, jp, zr) & ~32'd3;
    expCnt = expCnt + 32'd1;
`ifdef IFU_RETIRE_CNT_EN
    chk("cntAfter", retireCnt, expCnt);
`endif
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
  endtask

  initial begin
    doReset(3);
    doFetch(32'h3401_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("oriPcModel", expPc, 32'h0000_3004);
    doFetch(32'h8C22_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    doFetch(32'h1000_0003, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    doFetch(32'h0800_0C04, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    doFetch(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    doReset(3);
    doFetch(32'h3401_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    doFetch(32'h8C22_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    doFetch(32'h1000_0003, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    doFetch(32'hAC22_0004, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1);

    #1;
    chk("preWaitReq", 32'(imemReq), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midWaitRstPc", pc, 32'h0000_3000);
    chk("midWaitRstReq", 32'(imemReq), 32'd0);
    chk("midWaitRstValid", 32'(instValid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expPc  = 32'h0000_3000;
    expCnt = 32'd0;
    doFetch(32'h3401_0005, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (i % 5 == 0) w[31:26] = OP_BEQ;
      if (i % 7 == 0) w[31:26] = OP_J;
      doFetch(w, $urandom_range(1, 3), $urandom_range(0, 2),
              1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
    end

    chk("wrapLogSize", 32'(addrLog2.size() >= 2), 32'd1);
    if (addrLog2.size() >= 2) begin
      chk("wrapFirstAddr", addrLog2[0], 32'hFFFF_FFFC);
      chk("wrapSecondAddr", addrLog2[1], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the single-issue MIPS core. Holds the PC, requests words from instruction memory over a request/response handshake, registers the returned instruction, and presents `op` and the full word to the main control decoder. It consumes the decoder's `Branch`/`Jump` outputs plus the ALU `zero` flag to compute the next PC.

## Interface
- `PC_RESET`, `32'h0000_3000`, PC value loaded on reset
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  one-cycle fetch request
- `imem_addr`  out  32  word address of the request; equals `pc`
- `imem_rvalid`  in  1  response valid; the earliest legal assertion is the cycle after `imem_req`
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `stall`  in  1  downstream not ready; holds the current instruction
- `branch`  in  1  from the control decoder (`Branch`)
- `jump`  in  1  from the control decoder (`Jump`)
- `zero`  in  1  ALU equality result for the current instruction
- `inst_valid`  out  1  `inst` holds a fetched, not-yet-retired instruction
- `inst`  out  32  registered instruction word
- `op`  out  6  `inst[31:26]`, drives the decoder `op` input
- `pc`  out  32  address of `inst`
- `pc_plus4`  out  32  `pc + 4`

## Operation
- FSM states: REQ, WAIT, HOLD.
- **REQ**: `imem_req=1`, `imem_addr=pc`. Go to WAIT next cycle unconditionally.
- **WAIT**: `imem_req=0`. On `imem_rvalid`, set `inst<=imem_rdata`, `inst_valid<=1`, and go to HOLD.
- **HOLD**: `inst_valid=1`. While `stall=1`, hold all state. When `stall=0` the instruction retires: `pc<=npc`, `inst_valid<=0`, go to REQ.
- Next-PC priority:
  - `jump`: `{pc_plus4[31:28], inst[25:0], 2'b00}`
  - else `branch & zero`: `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`
  - else `pc_plus4`
- All adds are 32-bit modulo 2^32. `0xFFFF_FFFC + 4 = 0x0000_0000`.
- `pc[1:0]` is always `2'b00`. The low two bits of `PC_RESET` and `npc` are forced to zero.
- `imem_rvalid` outside WAIT is ignored.
- `branch`, `jump` and `zero` are sampled only in the HOLD retire cycle.
- `jump` and `branch` both high: `jump` wins.
- Reset values: `pc=PC_RESET`, state=REQ, `inst=0`, `inst_valid=0`, `imem_req=0` during reset. `op=0` and `pc_plus4=PC_RESET+4` follow from these.

## Timing
- Reset asserted at any time, including mid-WAIT: state and PC return to their reset values immediately. Instruction memory shares `rst`, so no stale response survives.
- First `imem_req` is in the first rising edge after `rst` deasserts.
- Fetch latency: `imem_req` in cycle N, `imem_rvalid` in cycle N+k (k≥1), `inst_valid` in cycle N+k+1.
- Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with k=1 and `stall=0`.
- `inst`, `op`, `pc` and `pc_plus4` are stable for the entire HOLD period.
- `npc` is combinational in HOLD. The PC update is registered on the retire edge.

## Configuration
- `IFU_RETIRE_CNT_EN` defined: adds output `retire_cnt` (32 bits), reset to 0, incremented on every HOLD cycle with `stall=0`, wrapping at 2^32.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_ORI=6'b001101`, `OP_LW=6'b100011`, `OP_SW=6'b101011`, `OP_BEQ=6'b000100`, `OP_J=6'b000010`)
  - default `PC_RESET`
  - fetch-state enum
- Sub-module `ifu_npc`: combinational next-PC select (inputs `pc_plus4`, `inst`, `branch`, `zero`, `jump`; output `npc`).

## Test plan
- **Reset**: hold `rst` 3 cycles, release → next cycle `imem_req=1`, `imem_addr=0x0000_3000`, `inst_valid=0`.
- **Sequential fetch**: k=1 memory returns `0x3401_0005` (ori), `stall=0`, decoder drives branch=0, jump=0 → `op=6'b001101`, `pc=0x3000`, next `imem_addr=0x0000_3004`.
- **Branch at `pc=0x3008`**: inst `0x1000_0003` (beq), `branch=1`.
  - `zero=1` → next `imem_addr=0x0000_3018`.
  - `zero=0` → next `imem_addr=0x0000_300C`.
- **Jump at `pc=0x300C`**: inst `0x0800_0C04`, `jump=1`, `branch=1`, `zero=1` → next `imem_addr=0x0000_3010` (jump priority).
- **Stall and delayed response**: `stall=1` for 4 HOLD cycles → `inst`/`pc` unchanged, no `imem_req`. Release → one retire, and `retire_cnt` (if enabled) increments by exactly 1. Separately, k=3 memory latency → `inst_valid` rises 4 cycles after `imem_req`.
- **Reset during WAIT and PC wrap**: `rst` pulsed during WAIT → `pc=0x3000`; a late `imem_rvalid` in REQ is ignored. With `PC_RESET=32'hFFFF_FFFC` → second `imem_addr=0x0000_0000`.
